// File: rtl/base_pkg.sv
// Shared constants and compile-time helpers for the base_* structural primitives.
package base_pkg;

  // Fill value used to model uninitialised storage in simulation.
  localparam logic [1:0] BASE_X_PATTERN = 2'b10;

  // Ceiling log2, never less than 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/base_fifo_ptr.sv
// Circular index register for base_fifo: async reset, sync clear, explicit wrap at depth-1.
module base_fifo_ptr
  import base_pkg::*;
#(
  parameter int unsigned depth = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_en,
  input  logic                     inc_en,
  output logic [clog2(depth)-1:0]  ptr
);

  localparam int unsigned PtrW = clog2(depth);

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Compare-and-reset wrap keeps non-power-of-two depths correct.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_en) begin
      ptr_d = '0;
    end else if (inc_en) begin
      ptr_d = (ptr_q == PtrW'(depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/base_fifo.sv
// Guarded enq/deq FIFO between pipeline stages; storage is unreset, control state is reset.
// Define BASE_FIFO_PIPE_EN to let a full FIFO accept an enq in the same cycle as a deq.
module base_fifo
  import base_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 2,
  parameter int unsigned cnt_w = $clog2(depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [width-1:0]  enq_in,
  input  logic              enq_en,
  output logic              enq_rdy,
  output logic [width-1:0]  deq_out,
  input  logic              deq_en,
  output logic              deq_rdy,
  input  logic              clr_en,
  output logic [cnt_w-1:0]  count
);

  localparam int unsigned PtrW = clog2(depth);

  logic [width-1:0] mem [depth];
  logic [PtrW-1:0]  rd_ptr, wr_ptr;
  logic [cnt_w-1:0] count_q, count_d;
  logic             full, empty, enq_fire, deq_fire;

  assign full  = (count_q == cnt_w'(depth));
  assign empty = (count_q == '0);

`ifdef BASE_FIFO_PIPE_EN
  // A same-cycle deq frees the slot, so a full FIFO can still accept.
  assign enq_rdy = !full | deq_en;
`else
  assign enq_rdy = !full;
`endif
  assign deq_rdy = !empty;
  assign deq_out = mem[rd_ptr];

  assign enq_fire = enq_en & enq_rdy;
  assign deq_fire = deq_en & deq_rdy;

  base_fifo_ptr #(
    .depth (depth)
  ) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_en (clr_en),
    .inc_en (deq_fire),
    .ptr    (rd_ptr)
  );

  base_fifo_ptr #(
    .depth (depth)
  ) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_en (clr_en),
    .inc_en (enq_fire),
    .ptr    (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (enq_fire && !clr_en) begin
      mem[wr_ptr] <= enq_in;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_en) begin
      count_d = '0;
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + cnt_w'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
